// File: rtl/handshake_skid.sv
// Valid/ready register slice with a two-entry skid buffer; s_ready comes straight from a flop.
// Also keeps bring-up counters for completed output transfers and downstream stall cycles.
module handshake_skid #(
    parameter int unsigned DW = 8,
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    input  logic          cnt_clr,
    output logic [CW-1:0] xfer_cnt,
    output logic [CW-1:0] stall_cnt
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]    r_state;
    logic [DW-1:0] r_main_data;
    logic [DW-1:0] r_skid_data;
    logic          r_s_ready;
    logic [CW-1:0] r_xfer_cnt;
    logic [CW-1:0] r_stall_cnt;

    logic [1:0]    w_state_nxt;
    logic [DW-1:0] w_main_nxt;
    logic [DW-1:0] w_skid_nxt;
    logic          w_m_valid;
    logic          w_in_fire;
    logic          w_out_fire;
    logic          w_stall;

    assign w_m_valid  = (r_state != ST_EMPTY);
    assign w_in_fire  = s_valid & r_s_ready;
    assign w_out_fire = w_m_valid & m_ready;
    assign w_stall    = w_m_valid & ~m_ready;

    // Next-state and data-load selection
    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main_data;
        w_skid_nxt  = r_skid_data;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_fire) begin
                    w_main_nxt  = s_data;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (w_in_fire && w_out_fire) begin
                    w_main_nxt = s_data;
                end else if (w_in_fire) begin
                    w_skid_nxt  = s_data;
                    w_state_nxt = ST_FULL;
                end else if (w_out_fire) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_out_fire) begin
                    w_main_nxt  = r_skid_data;
                    w_state_nxt = ST_BUSY;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // s_ready looks one state ahead so it is low exactly while the skid holds a beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_main_data <= '0;
            r_skid_data <= '0;
            r_s_ready   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_main_data <= w_main_nxt;
            r_skid_data <= w_skid_nxt;
            r_s_ready   <= (w_state_nxt != ST_FULL);
        end
    end

    // Transfer counter wraps; stall counter saturates; clear wins over increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_xfer_cnt  <= '0;
            r_stall_cnt <= '0;
        end else if (cnt_clr) begin
            r_xfer_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_out_fire) begin
                r_xfer_cnt <= r_xfer_cnt + CW'(1);
            end
            if (w_stall && !(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + CW'(1);
            end
        end
    end

    assign s_ready   = r_s_ready;
    assign m_valid   = w_m_valid;
    assign m_data    = r_main_data;
    assign xfer_cnt  = r_xfer_cnt;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_handshake_skid.sv
// Directed and scoreboarded bench for handshake_skid; a second instance with CW=4
// exercises counter wrap, saturation and clear priority.
module tb_handshake_skid;

    logic        clk;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic        cnt_clr;
    logic [15:0] xfer_cnt;
    logic [15:0] stall_cnt;

    logic        s4_valid;
    logic        s4_ready;
    logic [7:0]  s4_data;
    logic        m4_valid;
    logic        m4_ready;
    logic [7:0]  m4_data;
    logic        cnt4_clr;
    logic [3:0]  xfer4_cnt;
    logic [3:0]  stall4_cnt;

    int n_checks;
    int n_errors;

    handshake_skid #(.DW(8), .CW(16)) u_dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .cnt_clr(cnt_clr), .xfer_cnt(xfer_cnt), .stall_cnt(stall_cnt)
    );

    handshake_skid #(.DW(8), .CW(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .s_valid(s4_valid), .s_ready(s4_ready), .s_data(s4_data),
        .m_valid(m4_valid), .m_ready(m4_ready), .m_data(m4_data),
        .cnt_clr(cnt4_clr), .xfer_cnt(xfer4_cnt), .stall_cnt(stall4_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] exp_b;
        logic [7:0] held_d;
        logic [7:0] next_b;
        logic       fi, fo, held;
        int         sent, rcvd, cyc, stalls;

        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        s_valid  = 1'b1;
        s_data   = 8'h11;
        m_ready  = 1'b0;
        cnt_clr  = 1'b0;
        s4_valid = 1'b0;
        s4_data  = 8'h00;
        m4_ready = 1'b0;
        cnt4_clr = 1'b0;

        // 1: reset values, then release with a beat already offered
        tick();
        tick();
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'h0);
        check("rst_xfer", 32'(xfer_cnt), 32'd0);
        check("rst_stall", 32'(stall_cnt), 32'd0);
        rst = 1'b0;
        tick();
        check("rel_s_ready", 32'(s_ready), 32'd1);
        check("rel_no_accept", 32'(m_valid), 32'd0);
        tick();
        check("first_m_valid", 32'(m_valid), 32'd1);
        check("first_m_data", 32'(m_data), 32'h11);
        s_valid = 1'b0;
        m_ready = 1'b1;
        tick();
        check("first_drain", 32'(m_valid), 32'd0);
        check("first_xfer", 32'(xfer_cnt), 32'd1);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("clr_xfer", 32'(xfer_cnt), 32'd0);

        // 2: full-throughput streaming
        s_valid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            s_data = 8'(i);
            tick();
            check("stream_valid", 32'(m_valid), 32'd1);
            check("stream_data", 32'(m_data), 32'(i));
            check("stream_ready", 32'(s_ready), 32'd1);
        end
        s_valid = 1'b0;
        tick();
        check("stream_empty", 32'(m_valid), 32'd0);
        check("stream_xfer", 32'(xfer_cnt), 32'd8);
        check("stream_stall", 32'(stall_cnt), 32'd0);

        // 3: stall fills the skid, then drains in order
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'hA0;
        tick();
        check("stall_busy_data", 32'(m_data), 32'hA0);
        check("stall_busy_ready", 32'(s_ready), 32'd1);
        s_data = 8'hA1;
        tick();
        check("stall_full_ready", 32'(s_ready), 32'd0);
        check("stall_full_data", 32'(m_data), 32'hA0);
        check("stall_cnt1", 32'(stall_cnt), 32'd1);
        s_data = 8'hA2;
        tick();
        tick();
        check("stall_hold_ready", 32'(s_ready), 32'd0);
        check("stall_hold_valid", 32'(m_valid), 32'd1);
        check("stall_hold_data", 32'(m_data), 32'hA0);
        m_ready = 1'b1;
        tick();
        check("drain_a1", 32'(m_data), 32'hA1);
        check("drain_ready", 32'(s_ready), 32'd1);
        tick();
        check("drain_a2", 32'(m_data), 32'hA2);
        s_valid = 1'b0;
        tick();
        check("drain_empty", 32'(m_valid), 32'd0);
        check("drain_stall", 32'(stall_cnt), 32'd3);
        check("drain_xfer", 32'(xfer_cnt), 32'd3);

        // 4: random traffic against a scoreboard
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        sent   = 0;
        rcvd   = 0;
        cyc    = 0;
        stalls = 0;
        next_b = 8'h00;
        s_valid = 1'b0;
        while (rcvd < 1000 && cyc < 20000) begin
            fi     = s_valid & s_ready;
            fo     = m_valid & m_ready;
            held   = m_valid & ~m_ready;
            held_d = m_data;
            if (held) stalls++;
            if (fo) begin
                if (q.size() == 0) begin
                    check("rand_spurious", 32'(m_data), 32'hFFFF_FFFF);
                end else begin
                    exp_b = q.pop_front();
                    check("rand_order", 32'(m_data), 32'(exp_b));
                end
                rcvd++;
            end
            if (fi) begin
                q.push_back(s_data);
                sent++;
                next_b = next_b + 8'd1;
            end
            tick();
            cyc++;
            if (held) begin
                check("rand_hold_valid", 32'(m_valid), 32'd1);
                check("rand_hold_data", 32'(m_data), 32'(held_d));
            end
            if (q.size() == 2) check("rand_full_ready", 32'(s_ready), 32'd0);
            if (fi || !s_valid) begin
                s_valid = (sent < 1000) && ($urandom_range(0, 9) < 7);
                s_data  = next_b;
            end
            m_ready = ($urandom_range(0, 9) < 6);
        end
        check("rand_done", 32'(rcvd), 32'd1000);
        check("rand_empty", 32'(m_valid), 32'd0);
        check("rand_xfer", 32'(xfer_cnt), 32'd1000);
        check("rand_stall", 32'(stall_cnt), 32'(stalls));

        // 5: asynchronous reset while the skid is full
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'hB0;
        tick();
        s_data = 8'hB1;
        tick();
        s_valid = 1'b0;
        check("b_full_ready", 32'(s_ready), 32'd0);
        check("b_full_valid", 32'(m_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_m_valid", 32'(m_valid), 32'd0);
        check("arst_s_ready", 32'(s_ready), 32'd0);
        check("arst_m_data", 32'(m_data), 32'h0);
        tick();
        rst     = 1'b0;
        m_ready = 1'b1;
        tick();
        check("arst_rel_ready", 32'(s_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("arst_no_stale", 32'(m_valid), 32'd0);
        end
        check("arst_xfer", 32'(xfer_cnt), 32'd0);
        check("arst_stall", 32'(stall_cnt), 32'd0);

        // 6: narrow counters wrap, saturate, and clear wins over out_fire
        m4_ready = 1'b1;
        s4_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            s4_data = 8'(i);
            tick();
        end
        s4_valid = 1'b0;
        tick();
        check("c4_wrap", 32'(xfer4_cnt), 32'd1);
        check("c4_no_stall", 32'(stall4_cnt), 32'd0);
        m4_ready = 1'b0;
        s4_valid = 1'b1;
        s4_data  = 8'h5A;
        tick();
        s4_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("c4_sat", 32'(stall4_cnt), 32'd15);
        check("c4_hold_data", 32'(m4_data), 32'h5A);
        m4_ready = 1'b1;
        cnt4_clr = 1'b1;
        tick();
        cnt4_clr = 1'b0;
        check("c4_clr_xfer", 32'(xfer4_cnt), 32'd0);
        check("c4_clr_stall", 32'(stall4_cnt), 32'd0);
        check("c4_clr_drain", 32'(m4_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/handshake_skid.md
Name: handshake_skid

Overview:
- Valid/ready register slice that breaks the backward (ready) timing path. Our existing forward pipeline stage registers valid/data only; this block is its counterpart for the ready direction.
- s_ready is driven straight from a flop. No combinational path runs from m_ready to s_ready.
- A two-entry skid buffer absorbs the one beat that arrives while the downstream stalls.
- Sits between any valid/ready producer and consumer in the pipeline. Also provides transfer and stall counters for bring-up.

Parameters:
- DW, 8, data width in bits.
- CW, 16, width of the transfer and stall counters.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- s_valid  in  1  upstream beat valid.
- s_ready  out  1  registered; upstream may send.
- s_data  in  DW  upstream data.
- m_valid  out  1  registered; downstream beat valid.
- m_ready  in  1  downstream accepts.
- m_data  out  DW  registered downstream data.
- cnt_clr  in  1  synchronous clear of both counters.
- xfer_cnt  out  CW  number of completed output transfers.
- stall_cnt  out  CW  number of cycles with m_valid=1 and m_ready=0.

Behaviour:
- Registers: main_data (drives m_data), skid_data, 2-bit state, s_ready_q, xfer_cnt, stall_cnt.
- Reset is asynchronous, active-high. While rst=1:
  - state=EMPTY, m_valid=0, m_data=0, skid_data=0.
  - s_ready=0.
  - xfer_cnt=0, stall_cnt=0.
- Definitions: in_fire = s_valid & s_ready (s_ready is the registered value); out_fire = m_valid & m_ready.
- States:
  - EMPTY: m_valid=0, skid empty.
  - BUSY: m_valid=1, skid empty.
  - FULL: m_valid=1, skid holds one beat.
- Transitions from EMPTY:
  - in_fire: main_data<=s_data, go to BUSY.
  - Otherwise stay in EMPTY.
- Transitions from BUSY:
  - in_fire & out_fire: main_data<=s_data, stay in BUSY.
  - in_fire & ~out_fire: skid_data<=s_data, go to FULL.
  - ~in_fire & out_fire: go to EMPTY.
  - Otherwise hold.
- Transitions from FULL (in_fire is impossible because s_ready=0):
  - out_fire: main_data<=skid_data, go to BUSY.
  - Otherwise hold.
- Output derivation:
  - m_valid = (state != EMPTY), decoded directly from the state register.
  - s_ready_q <= (next_state != FULL).
  - First edge after reset release sets s_ready=1. A beat presented at that edge is not accepted.
- Latency:
  - One cycle from in_fire to m_valid when the block is EMPTY.
  - Full throughput: one beat per cycle with m_ready held high.
- Ordering and integrity:
  - Strict FIFO order.
  - No beat dropped or duplicated.
  - Data passes unmodified.
- Protocol assumptions and guarantees:
  - Upstream holds s_valid/s_data stable until accepted.
  - m_valid/m_data stay stable while m_valid=1 & m_ready=0.
  - m_valid never drops without an out_fire.
- Data registers load only on the listed events; they hold their value otherwise.
- Counters:
  - xfer_cnt increments on out_fire and wraps at 2^CW.
  - stall_cnt increments when m_valid & ~m_ready and saturates at all-ones.
  - cnt_clr=1 zeroes both counters, taking priority over an increment in the same cycle.
- Reset mid-operation: both buffered beats are discarded, and outputs go to their reset values immediately (asynchronous reset).

Test Plan:
1. Reset release with s_valid=1, s_data=0x11 held: no acceptance on the first edge. s_ready rises after that edge. m_valid=1, m_data=0x11 one cycle after the accepting edge.
2. Streaming 0x01..0x08 with m_ready=1 and s_valid continuous: output 0x01..0x08 on consecutive cycles; xfer_cnt=8, stall_cnt=0.
3. Stall: send 0xA0, then 0xA1, with m_ready=0:
   - State reaches FULL and s_ready drops on the next edge.
   - 0xA2 is held off by the upstream.
   - Raise m_ready: output is 0xA0, 0xA1, 0xA2 in order.
   - stall_cnt equals the number of stalled cycles.
4. Random s_valid and m_ready over 1000 beats with a scoreboard: in-order, lossless delivery. m_data stable during stalls. s_ready is never 1 while in FULL.
5. Assert rst asynchronously while in FULL (0xB0 and 0xB1 buffered): m_valid=0 and s_ready=0 immediately. After release no stale beat appears. Counters read 0.
6. Counters with CW=4:
   - 17 transfers give xfer_cnt=1 (wrap).
   - 20 stalled cycles give stall_cnt=15 (saturate).
   - cnt_clr together with out_fire gives xfer_cnt=0.
